// File: rtl/gpio_pkg.sv
// Shared op codes, GPIO register map and FSM encoding for the GPIO bus master.
package gpio_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_RMW   = 2'b10,
    OP_POLL  = 2'b11
  } op_e;

  localparam logic [1:0] ADDR_GPI1 = 2'd0;
  localparam logic [1:0] ADDR_GPI2 = 2'd1;
  localparam logic [1:0] ADDR_GPO1 = 2'd2;
  localparam logic [1:0] ADDR_GPO2 = 2'd3;

  // Bit i set: address i accepts writes (gpO1/gpO2 only).
  localparam logic [3:0] WR_MASK_DEFAULT = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_POLL   = 3'd5,
    S_RESP   = 3'd6
  } state_e;

endpackage

// File: rtl/gpio_poll_ctr.sv
// Poll read counter: clear wins over increment; last_o flags that the read in
// progress is the MAX-th one. Single-cycle update, no backpressure.
module gpio_poll_ctr #(
  parameter int W   = 16,
  parameter int MAX = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [W-1:0] LAST_CNT = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/gpio_bus_master.sv
// GPIO bus initiator: one command in flight; READ/WRITE respond 2 cycles after accept, RMW 3,
// POLL 1+reads; response held stable until rsp_ready, cmd_ready only while idle.
module gpio_bus_master
  import gpio_pkg::*;
#(
  parameter int                DW       = 32,
  parameter int                AW       = 2,
  parameter logic [2**AW-1:0]  WR_MASK  = WR_MASK_DEFAULT,
  parameter int                POLL_W   = 16,
  parameter int                POLL_MAX = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic [DW-1:0] cmd_mask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] bus_a,
  output logic          bus_we,
  output logic [DW-1:0] bus_wd,
  input  logic [DW-1:0] bus_rd
);

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] mask_q, mask_d;
  logic [AW-1:0] bus_a_q, bus_a_d;
  logic          bus_we_q, bus_we_d;
  logic [DW-1:0] bus_wd_q, bus_wd_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          ctr_clr, ctr_inc, ctr_last;
  logic [DW-1:0] rmw_new;
  logic          poll_match;

  assign rmw_new    = (bus_rd & ~mask_q) | (data_q & mask_q);
  assign poll_match = ((bus_rd ^ data_q) & mask_q) == '0;

  gpio_poll_ctr #(
    .W   (POLL_W),
    .MAX (POLL_MAX)
  ) u_poll_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ctr_clr),
    .inc_i  (ctr_inc),
    .last_o (ctr_last)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mask_d     = mask_q;
    bus_a_d    = bus_a_q;
    bus_we_d   = 1'b0;
    bus_wd_d   = bus_wd_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ctr_clr    = 1'b0;
    ctr_inc    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          data_d    = cmd_data;
          mask_d    = cmd_mask;
          bus_a_d   = cmd_addr;
          rsp_err_d = 1'b0;
          case (cmd_op)
            OP_READ:  state_d = S_RD;
            OP_WRITE: begin
              // Writes to read-only addresses never reach the bus.
              if (WR_MASK[cmd_addr]) begin
                state_d  = S_WR;
                bus_we_d = 1'b1;
                bus_wd_d = cmd_data;
              end else begin
                state_d    = S_RESP;
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
              end
            end
            OP_RMW:   state_d = S_RMW_RD;
            default: begin
              state_d = S_POLL;
              ctr_clr = 1'b1;
            end
          endcase
        end
      end
      S_RD: begin
        rsp_data_d = bus_rd;
        state_d    = S_RESP;
      end
      S_WR: begin
        rsp_data_d = data_q;
        state_d    = S_RESP;
      end
      S_RMW_RD: begin
        if (WR_MASK[bus_a_q]) begin
          bus_we_d   = 1'b1;
          bus_wd_d   = rmw_new;
          rsp_data_d = rmw_new;
          state_d    = S_RMW_WR;
        end else begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RMW_WR: state_d = S_RESP;
      S_POLL: begin
        ctr_inc = 1'b1;
        // A match on the final permitted read still wins over the timeout.
        if (poll_match) begin
          rsp_data_d = bus_rd;
          state_d    = S_RESP;
        end else if (ctr_last) begin
          rsp_data_d = bus_rd;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      mask_q     <= '0;
      bus_a_q    <= '0;
      bus_we_q   <= 1'b0;
      bus_wd_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      bus_a_q    <= bus_a_d;
      bus_we_q   <= bus_we_d;
      bus_wd_q   <= bus_wd_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign bus_a     = bus_a_q;
  assign bus_we    = bus_we_q;
  assign bus_wd    = bus_wd_q;

endmodule
